// File: rtl/adler32_check.sv
// Adler-32 receive checker: sums a sized payload and compares it with a 4-byte trailer.
// Optional macro ADLER32_CHECK_OVERRUN_EN builds sticky overrun detection.
module adler32_check #(
   parameter int SIZE_W = 32,
   parameter int MOD    = 65521
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              size_valid,
   input  logic [SIZE_W-1:0] size,
   input  logic              data_valid,
   input  logic [7:0]        data,
   output logic              busy,
   output logic              done,
   output logic              match,
   output logic [31:0]       computed,
   output logic [31:0]       received,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      TRAILER,
      DONE
   } state_t;

   localparam logic [16:0]       MOD17   = 17'(MOD);
   localparam logic [SIZE_W-1:0] CNT_ONE = SIZE_W'(1);

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       a;
   logic [15:0]       b;
   logic [SIZE_W-1:0] count;
   logic [2:0]        tcnt;
   logic [16:0]       a_sum;
   logic [16:0]       a_red;
   logic [16:0]       b_sum;
   logic [16:0]       b_red;
   logic [15:0]       a_nxt;
   logic [15:0]       b_nxt;
   logic              pay_byte;
   logic              trl_byte;

   // byte qualification and one modular Adler step
   always_comb begin
      pay_byte = data_valid && !size_valid && (state == PAYLOAD);
      trl_byte = data_valid && !size_valid && (state == TRAILER);
      a_sum    = {1'b0, a} + {9'b0, data};
      a_red    = a_sum - MOD17;
      a_nxt    = (a_sum >= MOD17) ? a_red[15:0] : a_sum[15:0];
      b_sum    = {1'b0, b} + {1'b0, a_nxt};
      b_red    = b_sum - MOD17;
      b_nxt    = (b_sum >= MOD17) ? b_red[15:0] : b_sum[15:0];
   end

   // state register
   always_ff @(posedge clock or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state: size_valid restarts from anywhere
   always_comb begin
      state_nxt = state;
      if (size_valid) begin
         state_nxt = (size != '0) ? PAYLOAD : TRAILER;
      end else begin
         case (state)
            PAYLOAD: if (data_valid && count == CNT_ONE) state_nxt = TRAILER;
            TRAILER: if (data_valid && tcnt == 3'd1)     state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   // checksum, payload counter and trailer assembly
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         a        <= 16'd1;
         b        <= 16'd0;
         count    <= '0;
         tcnt     <= 3'd0;
         received <= 32'd0;
      end else if (size_valid) begin
         a        <= 16'd1;
         b        <= 16'd0;
         count    <= size;
         tcnt     <= 3'd4;
         received <= 32'd0;
      end else if (pay_byte) begin
         a     <= a_nxt;
         b     <= b_nxt;
         count <= count - CNT_ONE;
      end else if (trl_byte) begin
         received <= {received[23:0], data};
         tcnt     <= tcnt - 3'd1;
      end
   end

   // status outputs derived from state
   always_comb begin
      computed = {b, a};
      busy     = (state == PAYLOAD) || (state == TRAILER);
      done     = (state == DONE);
      match    = done && (computed == received);
   end

`ifdef ADLER32_CHECK_OVERRUN_EN
   // sticky flag for bytes arriving while no frame is open
   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         overrun <= 1'b0;
      else if (size_valid)
         overrun <= 1'b0;
      else if (data_valid && (state == IDLE || state == DONE))
         overrun <= 1'b1;
   end
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_adler32_check.sv
// Self-checking bench for adler32_check.
// Reference checksum computed from the Adler-32 definition with plain modular arithmetic.
module tb_adler32_check;

   typedef logic [7:0] bq_t[$];

   logic        clock = 1'b0;
   logic        rst;
   logic        size_valid;
   logic [31:0] size;
   logic        data_valid;
   logic [7:0]  data;
   logic        busy;
   logic        done;
   logic        match;
   logic [31:0] computed;
   logic [31:0] received;
   logic        overrun;

   int tests = 0;
   int fails = 0;

   adler32_check #(.SIZE_W(32), .MOD(65521)) dut (
      .clock      (clock),
      .rst        (rst),
      .size_valid (size_valid),
      .size       (size),
      .data_valid (data_valid),
      .data       (data),
      .busy       (busy),
      .done       (done),
      .match      (match),
      .computed   (computed),
      .received   (received),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] adler_ref(input bq_t q);
      int unsigned sa = 1;
      int unsigned sb = 0;
      foreach (q[i]) begin
         sa = (sa + q[i]) % 65521;
         sb = (sb + sa) % 65521;
      end
      return {sb[15:0], sa[15:0]};
   endfunction

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic start(input int unsigned n);
      size_valid = 1'b1;
      size       = n;
      @(posedge clock);
      #1;
      size_valid = 1'b0;
   endtask

   task automatic put(input logic [7:0] v, input int maxgap);
      idle_cycles($urandom_range(0, maxgap));
      data_valid = 1'b1;
      data       = v;
      @(posedge clock);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic run_frame(input string name, input bq_t q,
                            input logic [31:0] trailer, input int maxgap,
                            input bit do_start);
      int unsigned sa = 1;
      int unsigned sb = 0;
      logic [31:0] exp;
      logic [31:0] ref_sum;
      ref_sum = adler_ref(q);
      if (do_start) start(q.size());
      tests++;
      if (computed !== 32'h1 || busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL %s start: computed=%h busy=%b done=%b want 00000001/1/0",
                  name, computed, busy, done);
      end
      foreach (q[i]) begin
         put(q[i], maxgap);
         sa = (sa + q[i]) % 65521;
         sb = (sb + sa) % 65521;
         exp = {sb[15:0], sa[15:0]};
         tests++;
         if (computed !== exp) begin
            fails++;
            $display("FAIL %s byte%0d computed: got %h want %h", name, i, computed, exp);
         end
      end
      for (int k = 3; k >= 0; k--) put(trailer[8*k +: 8], maxgap);
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s end state: done=%b busy=%b want 1/0", name, done, busy);
      end
      tests++;
      if (computed !== ref_sum || received !== trailer) begin
         fails++;
         $display("FAIL %s result: computed=%h received=%h want %h/%h",
                  name, computed, received, ref_sum, trailer);
      end
      tests++;
      if (match !== (ref_sum == trailer)) begin
         fails++;
         $display("FAIL %s match: got %b want %b", name, match, ref_sum == trailer);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      size_valid = 1'b0;
      size = '0;
      data_valid = 1'b0;
      data = '0;
      idle_cycles(3);
      rst = 1'b0;
      idle_cycles(1);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || match !== 1'b0 || overrun !== 1'b0 ||
          computed !== 32'h1 || received !== 32'h0) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b match=%b ovr=%b comp=%h rcv=%h want 0/0/0/0/00000001/0",
                  busy, done, match, overrun, computed, received);
      end
      put(8'h5A, 0);
      tests++;
      if (computed !== 32'h1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_ignore: computed=%h busy=%b want 00000001/0", computed, busy);
      end
   endtask

   task automatic test_abc();
      run_frame("abc", str2q("abc"), 32'h024D0127, 0, 1);
      tests++;
      if (computed !== 32'h024D0127 || match !== 1'b1) begin
         fails++;
         $display("FAIL abc_const: computed=%h match=%b want 024d0127/1", computed, match);
      end
   endtask

   task automatic test_wikipedia();
      run_frame("wiki_ok", str2q("Wikipedia"), 32'h11E60398, 1, 1);
      run_frame("wiki_bad", str2q("Wikipedia"), 32'h11E60399, 1, 1);
      tests++;
      if (match !== 1'b0 || done !== 1'b1 || received !== 32'h11E60399) begin
         fails++;
         $display("FAIL wiki_bad_const: match=%b done=%b rcv=%h want 0/1/11e60399",
                  match, done, received);
      end
   endtask

   task automatic test_zero_size();
      bq_t q;
      run_frame("zero", q, 32'h00000001, 2, 1);
   endtask

   task automatic test_ff_wrap();
      bq_t q;
      for (int i = 0; i < 300; i++) q.push_back(8'hFF);
      run_frame("ff300", q, 32'hB90F2AE4, 3, 1);
      tests++;
      if (computed !== 32'hB90F2AE4) begin
         fails++;
         $display("FAIL ff300_const: computed=%h want b90f2ae4", computed);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         bq_t q;
         logic [31:0] t;
         int n = $urandom_range(0, 40);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         t = adler_ref(q);
         if ($urandom_range(0, 1) == 1) t = t ^ (32'h1 << $urandom_range(0, 31));
         run_frame($sformatf("rand%0d", k), q, t, 2, 1);
      end
   endtask

   task automatic test_reset_mid();
      start(10);
      put(8'h11, 0);
      put(8'h22, 0);
      #2 rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || computed !== 32'h1 || received !== 32'h0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: busy=%b comp=%h rcv=%h done=%b want 0/00000001/0/0",
                  busy, computed, received, done);
      end
      @(posedge clock);
      #1 rst = 1'b0;
      run_frame("abc_after_rst", str2q("abc"), 32'h024D0127, 0, 1);
   endtask

   task automatic test_restart();
      start(6);
      put(8'h99, 0);
      put(8'h77, 0);
      put(8'h55, 0);
      size_valid = 1'b1;
      size       = 3;
      data_valid = 1'b1;
      data       = 8'hAA;
      @(posedge clock);
      #1;
      size_valid = 1'b0;
      data_valid = 1'b0;
      run_frame("abc_restart", str2q("abc"), 32'h024D0127, 1, 0);
      start(2);
      put(8'h01, 0);
      put(8'h02, 0);
      put(8'hDE, 0);
      run_frame("abc_restart_trl", str2q("abc"), 32'h024D0127, 0, 1);
   endtask

   task automatic test_done_hold();
      logic [31:0] c0;
      logic [31:0] r0;
      bq_t q;
      q = str2q("abc");
      run_frame("hold_pre", q, 32'h024D0127, 0, 1);
      c0 = adler_ref(q);
      r0 = 32'h024D0127;
      put(8'h3C, 0);
      idle_cycles(2);
      tests++;
      if (done !== 1'b1 || match !== 1'b1 || computed !== c0 || received !== r0) begin
         fails++;
         $display("FAIL done_hold: done=%b match=%b comp=%h rcv=%h want 1/1/%h/%h",
                  done, match, computed, received, c0, r0);
      end
      tests++;
`ifdef ADLER32_CHECK_OVERRUN_EN
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_set: got %b want 1", overrun);
      end
`else
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_tied: got %b want 0", overrun);
      end
`endif
      start(1);
      tests++;
      if (overrun !== 1'b0 || done !== 1'b0 || match !== 1'b0) begin
         fails++;
         $display("FAIL overrun_clear: ovr=%b done=%b match=%b want 0/0/0",
                  overrun, done, match);
      end
      put(8'h61, 0);
      for (int k = 3; k >= 0; k--) put(8'h00, 0);
      tests++;
      if (done !== 1'b1 || match !== 1'b0 || computed !== 32'h00620062) begin
         fails++;
         $display("FAIL one_byte: done=%b match=%b comp=%h want 1/0/00620062",
                  done, match, computed);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_wikipedia();
      test_zero_size();
      test_ff_wrap();
      test_random();
      test_reset_mid();
      test_restart();
      test_done_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
